// File: rtl/drink_dispenser_ctrl_if.sv
// Front-panel / valve-driver bundle for the drink dispenser controller.
// The panel side drives requests (master); the controller drives valves and status (slave).
interface drink_dispenser_ctrl_if #(
  parameter int N_DRINKS = 4,
  parameter int N_ADDONS = 2
);
  logic [N_DRINKS-1:0] drink_req;
  logic [N_ADDONS-1:0] addon_req;
  logic                cancel;
  logic [N_DRINKS-1:0] valve;
  logic [N_ADDONS-1:0] addon_valve;
  logic                busy;
  logic                done;
  logic                error;
  logic [2:0]          state;

  modport master (
    output drink_req, addon_req, cancel,
    input  valve, addon_valve, busy, done, error, state
  );

  modport slave (
    input  drink_req, addon_req, cancel,
    output valve, addon_valve, busy, done, error, state
  );
endinterface

// File: rtl/drink_dispenser_ctrl.sv
// Beverage dispenser controller: timed brew on one drink valve, then timed doses on each
// requested add-on valve (lowest bit first), with cancel, request rejection and done pulse.
module drink_dispenser_ctrl #(
  parameter int N_DRINKS  = 4,
  parameter int N_ADDONS  = 2,
  parameter int TICK_DIV  = 4,
  parameter int BREW_TIME = 3,
  parameter int ADD_TIME  = 2,
  parameter int TW        = 8
) (
  input logic                   CLK,
  input logic                   RESET,
  drink_dispenser_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BREW = 3'd1,
    ADD  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t              state_q, state_n;
  logic [N_DRINKS-1:0] sel_q, sel_n;
  logic [N_ADDONS-1:0] amask_q, amask_n;
  logic [PW-1:0]       presc_q, presc_n;
  logic [TW-1:0]       timer_q, timer_n;
  logic                armed_q, armed_n;

  logic                tick, expire, onehot;
  logic [N_DRINKS-1:0] valve_n;
  logic [N_ADDONS-1:0] addon_n;
  logic                busy_n, done_n, error_n;

  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign expire = (state_q == BREW) ? (timer_q == TW'(BREW_TIME - 1))
                                    : (timer_q == TW'(ADD_TIME - 1));
  assign onehot = (bus.drink_req != '0) &&
                  ((bus.drink_req & (bus.drink_req - N_DRINKS'(1))) == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q         <= IDLE;
      sel_q           <= '0;
      amask_q         <= '0;
      presc_q         <= '0;
      timer_q         <= '0;
      armed_q         <= 1'b1;
      bus.valve       <= '0;
      bus.addon_valve <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.state       <= '0;
    end else begin
      state_q         <= state_n;
      sel_q           <= sel_n;
      amask_q         <= amask_n;
      presc_q         <= presc_n;
      timer_q         <= timer_n;
      armed_q         <= armed_n;
      bus.valve       <= valve_n;
      bus.addon_valve <= addon_n;
      bus.busy        <= busy_n;
      bus.done        <= done_n;
      bus.error       <= error_n;
      bus.state       <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    amask_n = amask_q;
    presc_n = presc_q;
    timer_n = timer_q;
    armed_n = armed_q;
    unique case (state_q)
      IDLE: begin
        if (bus.drink_req == '0) begin
          armed_n = 1'b1;
        end else if (armed_q) begin
          if (onehot) begin
            state_n = BREW;
            sel_n   = bus.drink_req;
            amask_n = bus.addon_req;
            presc_n = '0;
            timer_n = '0;
          end else begin
            state_n = ERR;
          end
        end
      end
      BREW, ADD: begin
        if (bus.cancel) begin
          state_n = IDLE;
          armed_n = 1'b0;
          sel_n   = '0;
          amask_n = '0;
        end else if (tick) begin
          presc_n = '0;
          if (expire) begin
            // Timer restarts here so a following dose begins on the very next cycle.
            timer_n = '0;
            if (state_q == BREW) begin
              state_n = (amask_q != '0) ? ADD : DONE;
            end else begin
              amask_n = amask_q & (amask_q - N_ADDONS'(1));
              if (amask_n == '0) state_n = DONE;
            end
          end else begin
            timer_n = timer_q + TW'(1);
          end
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
      DONE, ERR: begin
        state_n = IDLE;
        armed_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    valve_n = '0;
    addon_n = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    error_n = 1'b0;
    unique case (state_n)
      BREW: begin
        valve_n = sel_n;
        busy_n  = 1'b1;
      end
      ADD: begin
        addon_n = amask_n & (~amask_n + N_ADDONS'(1));
        busy_n  = 1'b1;
      end
      DONE: begin
        done_n = 1'b1;
        busy_n = 1'b1;
      end
      ERR:     error_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_drink_dispenser_ctrl.sv
// Directed bench for drink_dispenser_ctrl with default parameters (12-cycle brew, 8-cycle doses).
module tb_drink_dispenser_ctrl;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  drink_dispenser_ctrl_if #(.N_DRINKS(4), .N_ADDONS(2)) bus ();

  drink_dispenser_ctrl #(
    .N_DRINKS(4), .N_ADDONS(2), .TICK_DIV(4), .BREW_TIME(3), .ADD_TIME(2), .TW(8)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] v, input logic [1:0] a,
                         input logic b, input logic d, input logic e, input logic [2:0] s);
    chk({tag, ".valve"}, 8'(bus.valve), 8'(v));
    chk({tag, ".addon"}, 8'(bus.addon_valve), 8'(a));
    chk({tag, ".busy"},  8'(bus.busy), 8'(b));
    chk({tag, ".done"},  8'(bus.done), 8'(d));
    chk({tag, ".error"}, 8'(bus.error), 8'(e));
    chk({tag, ".state"}, 8'(bus.state), 8'(s));
  endtask

  // Leave the request low long enough for the controller to re-arm.
  task automatic idle_gap();
    bus.drink_req = '0;
    bus.addon_req = '0;
    bus.cancel    = 1'b0;
    step();
    step();
  endtask

  // Full dispense: request held one cycle, 12 brew cycles, 8 per add-on (bit 0 first), done, idle.
  task automatic dispense(input string tag, input logic [3:0] d, input logic [1:0] a);
    bus.drink_req = d;
    bus.addon_req = a;
    step();
    bus.drink_req = '0;
    bus.addon_req = '0;
    for (int i = 0; i < 12; i++) begin
      chk_all({tag, ".brew"}, d, 2'b00, 1'b1, 1'b0, 1'b0, 3'd1);
      step();
    end
    for (int b = 0; b < 2; b++) begin
      if (a[b]) begin
        for (int i = 0; i < 8; i++) begin
          chk_all({tag, ".add"}, 4'b0000, 2'(1 << b), 1'b1, 1'b0, 1'b0, 3'd2);
          step();
        end
      end
    end
    chk_all({tag, ".done"}, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 3'd3);
    step();
    chk_all({tag, ".idle"}, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    idle_gap();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    RESET         = 1'b1;
    bus.drink_req = '0;
    bus.addon_req = '0;
    bus.cancel    = 1'b0;
    step();
    chk_all("reset", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    RESET = 1'b0;
    step();
    chk_all("post_reset", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);

    // 1 and 2: single add-on, then no add-ons
    dispense("t1", 4'b0001, 2'b01);
    dispense("t2", 4'b0100, 2'b00);

    // 3: multi-bit request rejected once, no repeat while held
    bus.drink_req = 4'b1111;
    bus.addon_req = 2'b11;
    step();
    chk_all("t3.err", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 3'd4);
    step();
    chk_all("t3.idle", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    chk_all("t3.held", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    idle_gap();

    // 4: both add-ons back to back
    dispense("t4", 4'b0010, 2'b11);

    // 5: cancel on brew cycle 6, held request must not re-dispense
    bus.drink_req = 4'b0001;
    step();
    for (int i = 1; i < 6; i++) step();
    chk_all("t5.c6", 4'b0001, 2'b00, 1'b1, 1'b0, 1'b0, 3'd1);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    chk_all("t5.c7", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) step();
    chk_all("t5.held", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    bus.drink_req = '0;
    step();
    bus.drink_req = 4'b0001;
    step();
    chk_all("t5.redo", 4'b0001, 2'b00, 1'b1, 1'b0, 1'b0, 3'd1);
    bus.drink_req = '0;
    // cancel coinciding with brew expiry (edge ending cycle 12)
    for (int i = 1; i < 12; i++) step();
    chk_all("t5b.c12", 4'b0001, 2'b00, 1'b1, 1'b0, 1'b0, 3'd1);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    chk_all("t5b.cancel_wins", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    chk_all("t5b.no_done", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    idle_gap();

    // 6: asynchronous reset during ADD, then a fresh dispense
    bus.drink_req = 4'b1000;
    bus.addon_req = 2'b01;
    step();
    bus.drink_req = '0;
    bus.addon_req = '0;
    for (int i = 0; i < 14; i++) step();
    chk_all("t6.add", 4'b0000, 2'b01, 1'b1, 1'b0, 1'b0, 3'd2);
    #2;
    RESET = 1'b1;
    #1;
    chk_all("t6.async", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    RESET = 1'b0;
    step();
    chk_all("t6.after", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    dispense("t6.fresh", 4'b0100, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
